// File: rtl/text_console_pkg.sv
// Shared constants for the text console: cell geometry, control codes and
// write-FSM state encoding.
package text_console_pkg;

   localparam int CELL_W = 8;
   localparam int CELL_H = 8;

   localparam int DEF_COLS = 80;
   localparam int DEF_ROWS = 60;
   localparam int ADDR_W   = $clog2(DEF_COLS * DEF_ROWS);

   localparam logic [7:0] CH_SPACE = 8'h20;
   localparam logic [7:0] CH_TILDE = 8'h7E;
   localparam logic [7:0] CH_LF    = 8'h0A;
   localparam logic [7:0] CH_CR    = 8'h0D;
   localparam logic [7:0] CH_FF    = 8'h0C;

   typedef logic [0:0] state_t;
   localparam state_t ST_IDLE  = 1'b0;
   localparam state_t ST_CLEAR = 1'b1;

   // Address width for a non-default screen geometry.
   function automatic int addr_w(input int cols, input int rows);
      return $clog2(cols * rows);
   endfunction

endpackage

// File: rtl/font.sv
// Compact 8x8 glyph ROM with a registered pixel output; pos_x 0 is the
// leftmost pixel (row MSB). Codes without a dedicated bitmap render as a box.
module font (
   input  logic       px_clk,
   input  logic [2:0] pos_x,
   input  logic [2:0] pos_y,
   input  logic [7:0] character,
   output logic       pixel
);
   localparam logic [63:0] G_SPACE = 64'h0000_0000_0000_0000;
   localparam logic [63:0] G_7     = 64'h7E06_0C18_3030_3000;
   localparam logic [63:0] G_A     = 64'h183C_6666_7E66_6600;
   localparam logic [63:0] G_BOX   = 64'hFF81_8181_8181_81FF;

   logic [63:0] glyph;
   logic [7:0]  row_bits;

   always_comb begin
      glyph = G_BOX;
      case (character)
         8'h20:   glyph = G_SPACE;
         8'h37:   glyph = G_7;
         8'h41:   glyph = G_A;
         default: glyph = G_BOX;
      endcase
      // row 0 occupies bits 63..56, so the row's top bit is 63 - 8*pos_y
      row_bits = glyph[{~pos_y, 3'b111} -: 8];
   end

   always_ff @(posedge px_clk) begin
      pixel <= row_bits[~pos_x];
   end

endmodule

// File: rtl/text_console_text_ram.sv
// Character store: one write port, one registered read port. A read and a
// write to the same cell on one edge return the previous contents.
module text_ram #(
   parameter int DEPTH = 4800,
   parameter int AW    = 13
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [AW-1:0] wr_addr_i,
   input  logic [7:0]    wr_data_i,
   input  logic [AW-1:0] rd_addr_i,
   output logic [7:0]    rd_data_o
);
   logic [7:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[wr_addr_i] <= wr_data_i;
      rd_data_o <= mem_q[rd_addr_i];
   end

endmodule

// File: rtl/text_console.sv
// Character-cell text console: host write FSM with cursor, and a 3-stage
// pixel pipeline (cell address -> text RAM read -> font lookup).
//
// state    | meaning
// ST_IDLE  | accepting host characters, wr_ready high
// ST_CLEAR | filling every cell with a space, one cell per cycle
module text_console
   import text_console_pkg::*;
#(
   parameter int COLS = 80,
   parameter int ROWS = 60
) (
   input  logic       px_clk,
   input  logic       reset,
   input  logic [9:0] px_x,
   input  logic [9:0] px_y,
   input  logic       active,
   input  logic [7:0] wr_char,
   input  logic       wr_valid,
   output logic       wr_ready,
   output logic [6:0] cursor_x,
   output logic [5:0] cursor_y,
   output logic       pixel,
   output logic       pixel_active
);
   localparam int CELLS = COLS * ROWS;
   localparam int AW    = addr_w(COLS, ROWS);

   logic [AW-1:0] cell_addr_q;
   logic [2:0]    s1_x_q, s1_y_q, s2_x_q, s2_y_q;
   logic          s1_act_q, s2_act_q, s3_act_q;
   logic [7:0]    rd_char;
   logic          font_px;

   state_t        state_q, state_d;
   logic [AW-1:0] clr_cnt_q, clr_cnt_d;
   logic [6:0]    cur_x_q, cur_x_d;
   logic [5:0]    cur_y_q, cur_y_d;
   logic [5:0]    row_next;
   logic          xfer;
   logic          we;
   logic [AW-1:0] wr_addr;
   logic [7:0]    wr_data;

   always_ff @(posedge px_clk) begin
      if (reset) begin
         s1_act_q <= 1'b0;
         s2_act_q <= 1'b0;
         s3_act_q <= 1'b0;
      end else begin
         s1_act_q <= active;
         s2_act_q <= s1_act_q;
         s3_act_q <= s2_act_q;
      end
      cell_addr_q <= AW'(px_y[9:3]) * AW'(COLS) + AW'(px_x[9:3]);
      s1_x_q      <= px_x[2:0];
      s1_y_q      <= px_y[2:0];
      s2_x_q      <= s1_x_q;
      s2_y_q      <= s1_y_q;
   end

   text_ram #(.DEPTH(CELLS), .AW(AW)) u_text_ram (
      .clk_i     (px_clk),
      .we_i      (we),
      .wr_addr_i (wr_addr),
      .wr_data_i (wr_data),
      .rd_addr_i (cell_addr_q),
      .rd_data_o (rd_char)
   );

   font u_font (
      .px_clk    (px_clk),
      .pos_x     (s2_x_q),
      .pos_y     (s2_y_q),
      .character (rd_char),
      .pixel     (font_px)
   );

   assign pixel        = font_px & s3_act_q;
   assign pixel_active = s3_act_q;

   assign wr_ready = (state_q == ST_IDLE);
   assign xfer     = wr_valid && wr_ready;
   assign row_next = (cur_y_q == 6'(ROWS - 1)) ? 6'd0 : cur_y_q + 6'd1;
   assign cursor_x = cur_x_q;
   assign cursor_y = cur_y_q;

   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      cur_x_d   = cur_x_q;
      cur_y_d   = cur_y_q;
      we        = 1'b0;
      wr_addr   = AW'(cur_y_q) * AW'(COLS) + AW'(cur_x_q);
      wr_data   = wr_char;
      if (state_q == ST_CLEAR) begin
         we      = 1'b1;
         wr_addr = clr_cnt_q;
         wr_data = CH_SPACE;
         if (clr_cnt_q == AW'(CELLS - 1)) begin
            state_d   = ST_IDLE;
            clr_cnt_d = '0;
            cur_x_d   = '0;
            cur_y_d   = '0;
         end else begin
            clr_cnt_d = clr_cnt_q + AW'(1);
         end
      end else if (xfer) begin
         if (wr_char >= CH_SPACE && wr_char <= CH_TILDE) begin
            we = 1'b1;
            if (cur_x_q == 7'(COLS - 1)) begin
               cur_x_d = '0;
               cur_y_d = row_next;
            end else begin
               cur_x_d = cur_x_q + 7'd1;
            end
         end else if (wr_char == CH_LF) begin
            cur_x_d = '0;
            cur_y_d = row_next;
         end else if (wr_char == CH_CR) begin
            cur_x_d = '0;
         end else if (wr_char == CH_FF) begin
            state_d   = ST_CLEAR;
            clr_cnt_d = '0;
         end
      end
   end

   always_ff @(posedge px_clk) begin
      if (reset) begin
         state_q   <= ST_CLEAR;
         clr_cnt_q <= '0;
         cur_x_q   <= '0;
         cur_y_q   <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
         cur_x_q   <= cur_x_d;
         cur_y_q   <= cur_y_d;
      end
   end

endmodule

// File: tb/tb_text_console.sv
// Directed bench for text_console: clear timing, cursor movement, glyph
// rendering through the pixel pipeline and read-during-write behaviour.
module tb_text_console;
   logic       px_clk = 1'b0;
   logic       reset;
   logic [9:0] px_x, px_y;
   logic       active;
   logic [7:0] wr_char;
   logic       wr_valid;
   logic       wr_ready;
   logic [6:0] cursor_x;
   logic [5:0] cursor_y;
   logic       pixel, pixel_active;

   int n_tests = 0;
   int n_fail  = 0;

   localparam logic [63:0] G_7    = 64'h7E06_0C18_3030_3000;
   localparam logic [63:0] G_A    = 64'h183C_6666_7E66_6600;
   localparam logic [63:0] ALL_ON = 64'hFFFF_FFFF_FFFF_FFFF;

   text_console #(.COLS(80), .ROWS(60)) dut (
      .px_clk       (px_clk),
      .reset        (reset),
      .px_x         (px_x),
      .px_y         (px_y),
      .active       (active),
      .wr_char      (wr_char),
      .wr_valid     (wr_valid),
      .wr_ready     (wr_ready),
      .cursor_x     (cursor_x),
      .cursor_y     (cursor_y),
      .pixel        (pixel),
      .pixel_active (pixel_active)
   );

   always #5 px_clk = ~px_clk;

   task automatic tick();
      @(posedge px_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_cursor(input string tag, input int x, input int y);
      chk({tag, "_x"}, 32'(cursor_x), 32'(x));
      chk({tag, "_y"}, 32'(cursor_y), 32'(y));
   endtask

   task automatic put_char(input logic [7:0] c);
      int n = 0;
      while (!wr_ready && n < 10000) begin
         tick();
         n++;
      end
      chk("put_ready", 32'(wr_ready), 32'd1);
      wr_char  = c;
      wr_valid = 1'b1;
      tick();
      wr_valid = 1'b0;
      wr_char  = 8'h00;
   endtask

   task automatic measure_clear(input string tag);
      int n = 0;
      while (!wr_ready && n < 6000) begin
         tick();
         n++;
      end
      chk(tag, 32'(n), 32'd4800);
   endtask

   // One probe pixel (3,0) per cell; every non-space glyph lights that pixel.
   task automatic scan_blank(input string tag);
      int ones = 0;
      int acts = 0;
      for (int k = 0; k < 4802; k++) begin
         if (k < 4800) begin
            px_x   = 10'((k % 80) * 8 + 3);
            px_y   = 10'((k / 80) * 8);
            active = 1'b1;
         end else begin
            active = 1'b0;
         end
         tick();
         if (k >= 2) begin
            ones += int'(pixel);
            acts += int'(pixel_active);
         end
      end
      chk({tag, "_ones"}, 32'(ones), 32'd0);
      chk({tag, "_active"}, 32'(acts), 32'd4800);
   endtask

   task automatic scan_cell(input string tag, input int col, input int row,
                            input logic [63:0] glyph, input logic [63:0] mask);
      for (int k = 0; k < 66; k++) begin
         if (k < 64) begin
            px_x   = 10'(col * 8 + k % 8);
            px_y   = 10'(row * 8 + k / 8);
            active = mask[63 - k];
         end else begin
            active = 1'b0;
         end
         tick();
         if (k >= 2) begin
            chk({tag, "_pix"}, 32'(pixel), 32'(glyph[65 - k] & mask[65 - k]));
            chk({tag, "_act"}, 32'(pixel_active), 32'(mask[65 - k]));
         end
      end
   endtask

   initial begin
      logic [63:0] mask7;
      reset    = 1'b1;
      px_x     = 10'd3;
      px_y     = 10'd0;
      active   = 1'b1;
      wr_char  = 8'h00;
      wr_valid = 1'b0;
      repeat (4) tick();
      chk("rst_pixel_active", 32'(pixel_active), 32'd0);
      chk("rst_pixel", 32'(pixel), 32'd0);
      chk("rst_wr_ready", 32'(wr_ready), 32'd0);
      chk_cursor("rst_cursor", 0, 0);
      reset  = 1'b0;
      active = 1'b0;
      measure_clear("init_clear_len");
      chk_cursor("init_cursor", 0, 0);
      scan_blank("init_blank");

      put_char(8'h37);
      chk_cursor("after_37", 1, 0);
      mask7 = ~((64'h1 << (63 - 3)) | (64'h1 << (63 - 50)));
      scan_cell("glyph_37", 0, 0, G_7, mask7);

      put_char(8'h0D);
      chk_cursor("cr_row0", 0, 0);
      for (int i = 0; i < 80; i++) put_char(8'h41);
      chk_cursor("row0_full", 0, 1);
      scan_cell("glyph_A_c79", 79, 0, G_A, ALL_ON);

      put_char(8'h0A);
      for (int i = 0; i < 5; i++) put_char(8'h41);
      chk_cursor("at_5_2", 5, 2);
      put_char(8'h0D);
      chk_cursor("cr_5_2", 0, 2);
      for (int i = 0; i < 5; i++) put_char(8'h41);
      put_char(8'h0A);
      chk_cursor("lf_5_2", 0, 3);
      put_char(8'h01);
      chk_cursor("ign_01", 0, 3);
      chk("ign_01_ready", 32'(wr_ready), 32'd1);
      put_char(8'h7F);
      chk_cursor("ign_7f", 0, 3);
      put_char(8'h1F);
      chk_cursor("ign_1f", 0, 3);
      put_char(8'h7E);
      chk_cursor("print_7e", 1, 3);
      put_char(8'h20);
      chk_cursor("print_20", 2, 3);
      put_char(8'h0D);

      for (int i = 0; i < 56; i++) put_char(8'h0A);
      chk_cursor("lf_to_59", 0, 59);
      put_char(8'h0A);
      chk_cursor("lf_wrap", 0, 0);
      for (int i = 0; i < 59; i++) put_char(8'h0A);
      for (int i = 0; i < 79; i++) put_char(8'h41);
      chk_cursor("at_79_59", 79, 59);
      put_char(8'h41);
      chk_cursor("screen_wrap", 0, 0);

      px_x   = 10'd2;
      px_y   = 10'd1;
      active = 1'b1;
      tick();
      active   = 1'b0;
      wr_char  = 8'h37;
      wr_valid = 1'b1;
      tick();
      wr_valid = 1'b0;
      wr_char  = 8'h00;
      tick();
      chk("rdw_old_pix", 32'(pixel), 32'd1);
      chk("rdw_old_act", 32'(pixel_active), 32'd1);
      chk_cursor("rdw_cursor", 1, 0);
      scan_cell("rdw_new", 0, 0, G_7, ALL_ON);

      put_char(8'h0D);
      for (int i = 0; i < 10; i++) put_char(8'h0A);
      for (int i = 0; i < 10; i++) put_char(8'h41);
      chk_cursor("at_10_10", 10, 10);
      put_char(8'h0C);
      chk("ff_ready_low", 32'(wr_ready), 32'd0);
      measure_clear("ff_clear_len");
      chk_cursor("ff_cursor", 0, 0);
      scan_blank("ff_blank");

      put_char(8'h41);
      put_char(8'h0C);
      repeat (100) tick();
      reset = 1'b1;
      tick();
      chk("mid_rst_ready", 32'(wr_ready), 32'd0);
      chk_cursor("mid_rst_cursor", 0, 0);
      chk("mid_rst_active", 32'(pixel_active), 32'd0);
      reset = 1'b0;
      measure_clear("restart_clear_len");
      chk_cursor("restart_cursor", 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/text_console.md
TEXT_CONSOLE -- requirements
Module: text_console

Interface
REQ-001 SHALL have parameter COLS, default 80, meaning text columns (8-pixel cells).
REQ-002 SHALL have parameter ROWS, default 60, meaning text rows (8-pixel cells).
REQ-003 SHALL have port px_clk  in  1  pixel clock, the only clock.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port px_x  in  10  current screen X position.
REQ-006 SHALL have port px_y  in  10  current screen Y position.
REQ-007 SHALL have port active  in  1  display-enable for the current px_x/px_y.
REQ-008 SHALL have port wr_char  in  8  character code from the host.
REQ-009 SHALL have port wr_valid  in  1  host offers wr_char.
REQ-010 SHALL have port wr_ready  out  1  block accepts wr_char this cycle.
REQ-011 SHALL have port cursor_x  out  7  current write column.
REQ-012 SHALL have port cursor_y  out  6  current write row.
REQ-013 SHALL have port pixel  out  1  glyph pixel, 1 = foreground.
REQ-014 SHALL have port pixel_active  out  1  active delayed to align with pixel.

Function
REQ-015 Pixel path SHALL be a 3-stage pipeline: cell address = (px_y>>3)*COLS + (px_x>>3) registered; text-RAM read registered; font lookup registered.
REQ-016 pixel and pixel_active SHALL appear exactly 3 px_clk cycles after the px_x/px_y/active they correspond to; px_x[2:0], px_y[2:0] and active SHALL be delayed to match.
REQ-017 pixel SHALL be 0 whenever the delayed active is 0.
REQ-018 Write FSM SHALL have states IDLE and CLEAR; wr_ready = 1 only in IDLE.
REQ-019 A transfer SHALL occur when wr_valid && wr_ready; at most one per cycle; wr_char is not held beyond the transfer cycle.
REQ-020 Printable code 0x20-0x7E SHALL be written at address cursor_y*COLS+cursor_x in the transfer cycle, then the cursor advances by one.
REQ-021 Cursor advance SHALL wrap cursor_x from COLS-1 to 0 with cursor_y+1, and cursor_y from ROWS-1 to 0; no scrolling.
REQ-022 0x0A (LF) SHALL set cursor_x=0 and advance cursor_y with the same wrap; 0x0D (CR) SHALL set cursor_x=0 only.
REQ-023 0x0C (FF) SHALL enter CLEAR; all other codes SHALL be accepted and ignored, with the cursor unchanged.
REQ-024 CLEAR SHALL write 0x20 to cells 0..COLS*ROWS-1, one cell per cycle, ascending, then set cursor to (0,0) and return to IDLE; it lasts exactly COLS*ROWS cycles.
REQ-025 When a pixel-path read and a write target the same cell in one cycle, the read SHALL return the old character.

Reset
REQ-026 reset SHALL force state CLEAR with clear counter 0, cursor (0,0), pixel 0, pixel_active 0, all pipeline valid/active bits 0, and wr_ready 0.
REQ-027 reset asserted during CLEAR SHALL restart clearing from cell 0.
REQ-028 After reset deassertion, wr_ready SHALL rise after exactly COLS*ROWS cycles.

Structure
REQ-029 Package text_console_pkg SHALL hold the following:
- CELL_W=8 and CELL_H=8
- ADDR_W = clog2(COLS*ROWS)
- CH_SPACE=0x20, CH_LF=0x0A, CH_CR=0x0D, CH_FF=0x0C
- the IDLE/CLEAR state type
REQ-030 The block SHALL contain one sub-module text_ram (simple dual-port: 1 write port, 1 registered read port, 8-bit x COLS*ROWS).
REQ-031 The block SHALL instantiate the existing font module for glyph lookup, driving px_clk, pos_x and pos_y from the delayed low bits, and character from the RAM read data.

Verification
REQ-032 Reset released -> wr_ready low for 4800 cycles, then high; full-frame scan -> pixel 0 everywhere.
REQ-033 After clear, write 0x37; scan px_x 0-7, px_y 0-7 with active=1 -> 3 cycles later, pixel rows equal the font glyph for 0x37, and pixel_active equals active delayed 3.
REQ-034 80 writes of 0x41 from (0,0) -> cursor (0,1); a write at (79,59) -> cursor (0,0).
REQ-035 The following cursor cases SHALL be covered:
- cursor (5,2), LF -> cursor (0,3)
- cursor (5,2), CR -> cursor (0,2)
- 0x01 -> cursor unchanged and wr_ready stays 1
REQ-036 FF at cursor (10,10) -> wr_ready low 4800 cycles, cursor (0,0), all cells 0x20; reset at clear cycle 100 -> a fresh 4800-cycle clear.
REQ-037 Write 0x41 to cell 0 in the same cycle cell 0 is read -> that frame shows the old glyph; the next frame shows 0x41.
